a1335_multi_poller: RTL and testbench
=====================================

Name: a1335_multi_poller

Overview:
Successor to the single-sensor A1335 angle reader. Polls up to NUM_SENSORS A1335 sensors on one shared I2C bus in round-robin order, reading the angle and, optionally, the status register of each. Runs as a single triggered sweep or continuously at a programmable interval. Sits between the myo_control register map and the existing i2c_master transaction engine, which is instantiated at the level above and connected through the i2c_* ports.

Parameters:
NUM_SENSORS, 4, number of sensor channels (1..16)
CLK_HZ, 50000000, clock frequency, documentation only
TIMEOUT_CYCLES, 200000, max cycles per transaction before abort
REG_ANGLE, 8'h20, angle register pointer
REG_STATUS, 8'h22, status register pointer

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  level; sampled in IDLE, begins a sweep
continuous  in  1  1 = re-sweep after interval; sampled at sweep end
read_status  in  1  1 = also read REG_STATUS per channel; sampled at sweep start
interval  in  32  idle cycles between continuous sweeps
device_ids  in  7*NUM_SENSORS  I2C address of channel k at [7k+6:7k]
channel_mask  in  NUM_SENSORS  1 = poll channel; sampled at sweep start
i2c_ena  out  1  transaction enable to i2c_master
i2c_addr  out  7  target address
i2c_rw  out  1  always 1 (read)
i2c_data_wr  out  32  {pointer, 24'h0}
i2c_nbytes  out  8  always 3
i2c_busy  in  1  engine busy
i2c_data_rd  in  32  read data; data bytes in [31:16]
i2c_ack_error  in  1  NACK seen
i2c_byte_counter  in  8  bytes transferred so far
angles  out  12*NUM_SENSORS  channel k angle at [12k+11:12k]
statuses  out  16*NUM_SENSORS  channel k status
valid  out  NUM_SENSORS  channel holds a good angle from the latest completed sweep
err  out  NUM_SENSORS  latest attempt on channel failed (NACK or timeout)
err_count  out  8*NUM_SENSORS  saturating per-channel failure count
busy  out  1  high from sweep start until return to IDLE
sweep_done  out  1  one-cycle pulse at end of each sweep

Behaviour:
- Reset values: all outputs 0, except angles, which reset to 12'd7 per channel to match the legacy block. FSM enters IDLE.
- States: IDLE, SELECT, ISSUE, DRAIN, STORE, NEXT, END, WAIT.
- IDLE: busy=0. On start=1, latch channel_mask and read_status, set ch=0, busy=1, go to SELECT.
- SELECT: if ch is masked off, go to NEXT. Otherwise set phase=ANGLE and go to ISSUE.
- ISSUE: drive i2c_addr, i2c_data_wr = {REG_ANGLE or REG_STATUS, 24'h0}, i2c_nbytes=3, i2c_ena=1; clear the timeout counter.
  - Hold i2c_ena until i2c_byte_counter >= 3, then drop i2c_ena and go to DRAIN.
- DRAIN: wait for i2c_busy=0 with i2c_ena=0, then go to STORE.
  - Timeout: if the timeout counter reaches TIMEOUT_CYCLES in ISSUE or DRAIN, force i2c_ena=0 and treat as a failure. The abort takes effect even if i2c_busy never falls.
- STORE, failure (i2c_ack_error=1 or timeout): err[ch]=1, valid[ch]=0, err_count[ch]+1 saturating at 255. Skip the remaining phase and go to NEXT.
- STORE, success, ANGLE phase: angles[ch] = i2c_data_rd[27:16], valid[ch]=1, err[ch]=0.
  - If read_status is latched, set phase=STATUS and return to ISSUE. Otherwise go to NEXT.
- STORE, success, STATUS phase: statuses[ch] = i2c_data_rd[31:16]; go to NEXT.
- NEXT: if ch == NUM_SENSORS-1, go to END; else ch+1 and go to SELECT.
- END: pulse sweep_done for one cycle. If continuous=1, load the interval counter and go to WAIT; else go to IDLE.
- WAIT: count down the interval. At 0, start a new sweep using freshly sampled mask and read_status. If continuous drops during WAIT, return to IDLE.
  - interval=0 means the next sweep starts the cycle after END.
- start while busy=1: ignored. Mask or mode changes mid-sweep: no effect until the next sweep start.
- All-zero mask: the sweep walks every channel through SELECT/NEXT and pulses sweep_done after NUM_SENSORS+2 cycles. No I2C traffic occurs.
- Outputs of unpolled channels hold their previous values.
- Reset mid-transaction drops i2c_ena immediately (asynchronous) and all state returns to reset values.
- Latency per channel: I2C time plus 3 cycles of FSM overhead.

Decomposition:
- Package a1335_pkg holds:
  - state enum and phase enum
  - A1335 register pointer constants
  - transaction byte count (3)
  - angle/status bit-slice constants
- One natural sub-module, a1335_txn: ISSUE/DRAIN/timeout handshake to i2c_master. It returns done, fail and data. The poller handles sequencing and storage.

Test Plan:
- NUM_SENSORS=4, mask=4'b1111, read_status=0, I2C model returns 0x0ABC0000: one sweep → all angles 12'hABC, valid=4'hF, sweep_done one pulse, four transactions to device_ids in order 0..3.
- Channel 2 NACKs → err=4'b0100, valid=4'b1011, err_count[2]=1, angles[2] unchanged; the next sweep succeeds → err[2]=0, err_count[2] stays 1.
- read_status=1, model returns angle 0x1123xxxx and status 0x5A5Axxxx → angles=12'h123, statuses=16'h5A5A, eight transactions with pointers alternating 0x20/0x22.
- Model holds busy high forever on channel 1 → abort after TIMEOUT_CYCLES, err[1]=1, sweep continues to channels 2 and 3.
- continuous=1, interval=100 → sweep_done pulses spaced by (sweep time + 100 + 1) cycles; dropping continuous during WAIT returns to IDLE with busy=0.
- Reset asserted while i2c_ena=1 → i2c_ena=0 same cycle, angles=7, valid=0, err_count=0, FSM in IDLE; mask=0 sweep → sweep_done after 6 cycles, no i2c_ena.

Source files
------------

// File: rtl/a1335_pkg.sv
// Shared types and constants for the multi-sensor A1335 angle poller.
// Register pointers, transaction size and read-data field positions.
package a1335_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_ISSUE,
      S_DRAIN,
      S_STORE,
      S_NEXT,
      S_END,
      S_WAIT
   } state_t;

   typedef enum logic {
      PH_ANGLE,
      PH_STATUS
   } phase_t;

   localparam logic [7:0]  A1335_REG_ANGLE  = 8'h20;
   localparam logic [7:0]  A1335_REG_STATUS = 8'h22;
   localparam logic [7:0]  TXN_NBYTES       = 8'd3;

   localparam int unsigned DATA_MSB = 31;
   localparam int unsigned DATA_LSB = 16;
   localparam int unsigned ANGLE_W  = 12;
   localparam int unsigned STATUS_W = 16;

   localparam logic [ANGLE_W-1:0] ANGLE_RST = 12'd7;

   function automatic logic [31:0] ptr_word(input logic [7:0] ptr);
      return {ptr, 24'h0};
   endfunction

endpackage

// File: rtl/a1335_txn.sv
// One register read through i2c_master: enable handshake, drain and abort.
// Reports completion, failure (NACK or timeout) and the returned data bytes.
module a1335_txn
   import a1335_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_issue,
   input  logic        i_drain,
   input  logic [6:0]  i_addr,
   input  logic [7:0]  i_ptr,
   output logic        o_i2c_ena,
   output logic [6:0]  o_i2c_addr,
   output logic        o_i2c_rw,
   output logic [31:0] o_i2c_data_wr,
   output logic [7:0]  o_i2c_nbytes,
   input  logic        i_i2c_busy,
   input  logic [31:0] i_i2c_data_rd,
   input  logic        i_i2c_ack_error,
   input  logic [7:0]  i_i2c_byte_counter,
   output logic        o_issued,
   output logic        o_done,
   output logic        o_fail,
   output logic [15:0] o_data
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

   logic [TW-1:0] r_timer;
   logic          r_fail;
   logic [15:0]   r_data;
   logic          w_active;
   logic          w_timeout;
   logic          w_unused_lo;

   assign w_active    = i_issue | i_drain;
   assign w_timeout   = w_active && (r_timer == TW'(TIMEOUT_CYCLES));
   assign w_unused_lo = ^i_i2c_data_rd[DATA_LSB-1:0];

   // ena is decoded from the caller's state, so an async reset drops it at once
   assign o_i2c_ena     = i_issue & ~w_timeout;
   assign o_i2c_addr    = w_active ? i_addr : 7'd0;
   assign o_i2c_data_wr = w_active ? ptr_word(i_ptr) : 32'd0;
   assign o_i2c_rw      = 1'b1;
   assign o_i2c_nbytes  = TXN_NBYTES;

   assign o_issued = i_issue & (i_i2c_byte_counter >= TXN_NBYTES);
   assign o_done   = w_timeout | (i_drain & ~i_i2c_busy);
   assign o_fail   = r_fail;
   assign o_data   = r_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
         r_fail  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_timer <= w_active ? r_timer + 1'b1 : '0;
         if (o_done) begin
            r_fail <= w_timeout | i_i2c_ack_error;
            r_data <= i_i2c_data_rd[DATA_MSB:DATA_LSB];
         end
      end
   end

endmodule

// File: rtl/a1335_multi_poller.sv
// Round-robin poller for up to 16 A1335 sensors on a shared I2C bus.
// Sequences channels and phases; a1335_txn performs each register read.
module a1335_multi_poller
   import a1335_pkg::*;
#(
   parameter int unsigned NUM_SENSORS    = 4,
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter logic [7:0]  REG_ANGLE      = A1335_REG_ANGLE,
   parameter logic [7:0]  REG_STATUS     = A1335_REG_STATUS
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      continuous,
   input  logic                      read_status,
   input  logic [31:0]               interval,
   input  logic [7*NUM_SENSORS-1:0]  device_ids,
   input  logic [NUM_SENSORS-1:0]    channel_mask,
   output logic                      i2c_ena,
   output logic [6:0]                i2c_addr,
   output logic                      i2c_rw,
   output logic [31:0]               i2c_data_wr,
   output logic [7:0]                i2c_nbytes,
   input  logic                      i2c_busy,
   input  logic [31:0]               i2c_data_rd,
   input  logic                      i2c_ack_error,
   input  logic [7:0]                i2c_byte_counter,
   output logic [12*NUM_SENSORS-1:0] angles,
   output logic [16*NUM_SENSORS-1:0] statuses,
   output logic [NUM_SENSORS-1:0]    valid,
   output logic [NUM_SENSORS-1:0]    err,
   output logic [8*NUM_SENSORS-1:0]  err_count,
   output logic                      busy,
   output logic                      sweep_done
);

   localparam int CW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

   if (CLK_HZ < 1 || NUM_SENSORS < 1 || NUM_SENSORS > 16) begin : g_bad_params
      $error("a1335_multi_poller: bad parameters");
   end

   state_t                                 r_state;
   state_t                                 w_next;
   phase_t                                 r_phase;
   logic [CW-1:0]                          r_ch;
   logic [CW-1:0]                          w_ch_inc;
   logic [NUM_SENSORS-1:0]                 r_mask;
   logic                                   r_rs;
   logic [31:0]                            r_wait;
   logic [NUM_SENSORS-1:0][ANGLE_W-1:0]    r_angle;
   logic [NUM_SENSORS-1:0][STATUS_W-1:0]   r_status;
   logic [NUM_SENSORS-1:0][7:0]            r_errcnt;
   logic [NUM_SENSORS-1:0]                 r_valid;
   logic [NUM_SENSORS-1:0]                 r_err;
   logic [NUM_SENSORS-1:0][6:0]            w_ids;
   logic                                   w_last;
   logic                                   w_sweep_start;
   logic                                   w_issued;
   logic                                   w_done;
   logic                                   w_fail;
   logic [15:0]                            w_data;
   logic [7:0]                             w_ptr;

   assign w_ids    = device_ids;
   assign w_last   = (r_ch == CW'(NUM_SENSORS - 1));
   assign w_ch_inc = r_ch + 1'b1;
   assign w_ptr    = (r_phase == PH_STATUS) ? REG_STATUS : REG_ANGLE;

   assign angles     = r_angle;
   assign statuses   = r_status;
   assign err_count  = r_errcnt;
   assign valid      = r_valid;
   assign err        = r_err;
   assign busy       = (r_state != S_IDLE);
   assign sweep_done = (r_state == S_END);

   a1335_txn #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_txn (
      .clock              (clock),
      .reset              (reset),
      .i_issue            (r_state == S_ISSUE),
      .i_drain            (r_state == S_DRAIN),
      .i_addr             (w_ids[r_ch]),
      .i_ptr              (w_ptr),
      .o_i2c_ena          (i2c_ena),
      .o_i2c_addr         (i2c_addr),
      .o_i2c_rw           (i2c_rw),
      .o_i2c_data_wr      (i2c_data_wr),
      .o_i2c_nbytes       (i2c_nbytes),
      .i_i2c_busy         (i2c_busy),
      .i_i2c_data_rd      (i2c_data_rd),
      .i_i2c_ack_error    (i2c_ack_error),
      .i_i2c_byte_counter (i2c_byte_counter),
      .o_issued           (w_issued),
      .o_done             (w_done),
      .o_fail             (w_fail),
      .o_data             (w_data)
   );

   // NEXT skips straight over masked-off channels, one cycle per channel
   always_comb begin
      w_next        = r_state;
      w_sweep_start = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next        = S_SELECT;
               w_sweep_start = 1'b1;
            end
         end
         S_SELECT: w_next = r_mask[r_ch] ? S_ISSUE : S_NEXT;
         S_ISSUE: begin
            if (w_done)
               w_next = S_STORE;
            else if (w_issued)
               w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_done)
               w_next = S_STORE;
         end
         S_STORE: begin
            if (!w_fail && r_phase == PH_ANGLE && r_rs)
               w_next = S_ISSUE;
            else
               w_next = S_NEXT;
         end
         S_NEXT: begin
            if (w_last)
               w_next = S_END;
            else if (r_mask[w_ch_inc])
               w_next = S_SELECT;
            else
               w_next = S_NEXT;
         end
         S_END: w_next = continuous ? S_WAIT : S_IDLE;
         S_WAIT: begin
            if (!continuous) begin
               w_next = S_IDLE;
            end else if (r_wait == 32'd0) begin
               w_next        = S_SELECT;
               w_sweep_start = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_phase  <= PH_ANGLE;
         r_ch     <= '0;
         r_mask   <= '0;
         r_rs     <= 1'b0;
         r_wait   <= '0;
         r_angle  <= {NUM_SENSORS{ANGLE_RST}};
         r_status <= '0;
         r_errcnt <= '0;
         r_valid  <= '0;
         r_err    <= '0;
      end else begin
         r_state <= w_next;
         if (w_sweep_start) begin
            r_mask <= channel_mask;
            r_rs   <= read_status;
            r_ch   <= '0;
         end
         if (r_state == S_SELECT)
            r_phase <= PH_ANGLE;
         if (r_state == S_NEXT && !w_last)
            r_ch <= w_ch_inc;
         if (r_state == S_END)
            r_wait <= interval;
         else if (r_state == S_WAIT && r_wait != 32'd0)
            r_wait <= r_wait - 32'd1;
         if (r_state == S_STORE) begin
            if (w_fail) begin
               r_err[r_ch]   <= 1'b1;
               r_valid[r_ch] <= 1'b0;
               if (r_errcnt[r_ch] != 8'hFF)
                  r_errcnt[r_ch] <= r_errcnt[r_ch] + 8'd1;
            end else if (r_phase == PH_ANGLE) begin
               r_angle[r_ch] <= w_data[ANGLE_W-1:0];
               r_valid[r_ch] <= 1'b1;
               r_err[r_ch]   <= 1'b0;
               if (r_rs)
                  r_phase <= PH_STATUS;
            end else begin
               r_status[r_ch] <= w_data[STATUS_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_a1335_multi_poller.sv
// Bench for a1335_multi_poller: table of sweeps against a behavioural
// i2c_master model, plus timing, continuous-mode and reset sequences.
module tb_a1335_multi_poller;

   localparam int N  = 4;
   localparam int TO = 60;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          continuous;
   logic          read_status;
   logic [31:0]   interval;
   logic [7*N-1:0] device_ids;
   logic [N-1:0]  channel_mask;
   logic          i2c_ena;
   logic [6:0]    i2c_addr;
   logic          i2c_rw;
   logic [31:0]   i2c_data_wr;
   logic [7:0]    i2c_nbytes;
   logic          i2c_busy;
   logic [31:0]   i2c_data_rd;
   logic          i2c_ack_error;
   logic [7:0]    i2c_byte_counter;
   logic [12*N-1:0] angles;
   logic [16*N-1:0] statuses;
   logic [N-1:0]  valid;
   logic [N-1:0]  err;
   logic [8*N-1:0] err_count;
   logic          busy;
   logic          sweep_done;

   always #5 clock = ~clock;

   a1335_multi_poller #(
      .NUM_SENSORS    (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .continuous       (continuous),
      .read_status      (read_status),
      .interval         (interval),
      .device_ids       (device_ids),
      .channel_mask     (channel_mask),
      .i2c_ena          (i2c_ena),
      .i2c_addr         (i2c_addr),
      .i2c_rw           (i2c_rw),
      .i2c_data_wr      (i2c_data_wr),
      .i2c_nbytes       (i2c_nbytes),
      .i2c_busy         (i2c_busy),
      .i2c_data_rd      (i2c_data_rd),
      .i2c_ack_error    (i2c_ack_error),
      .i2c_byte_counter (i2c_byte_counter),
      .angles           (angles),
      .statuses         (statuses),
      .valid            (valid),
      .err              (err),
      .err_count        (err_count),
      .busy             (busy),
      .sweep_done       (sweep_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [6:0] addr;
      logic [7:0] ptr;
   } txn_t;

   txn_t exp_q[$];
   int   txn_cnt = 0;
   int   ena_cycles = 0;
   int   done_cnt = 0;

   logic [15:0] m_aresp, m_sresp;
   logic [N-1:0] m_nack, m_hang;
   logic        m_busy, m_hung;
   logic [7:0]  m_ptr;
   logic [1:0]  m_ch;
   int          m_step;

   task automatic sb_txn();
      txn_t e;
      txn_cnt++;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL txn_unexpected: got addr %h ptr %h expected none",
                  i2c_addr, i2c_data_wr[31:24]);
      end else begin
         e = exp_q.pop_front();
         chk("txn_fields", {i2c_addr, i2c_data_wr, i2c_nbytes, i2c_rw},
             {e.addr, e.ptr, 24'h0, 8'd3, 1'b1});
      end
   endtask

   // behavioural i2c_master: 3 bytes, busy drops 9 cycles after accept
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy           <= 1'b0;
         m_hung           <= 1'b0;
         m_step           <= 0;
         m_ch             <= '0;
         m_ptr            <= '0;
         i2c_busy         <= 1'b0;
         i2c_byte_counter <= '0;
         i2c_ack_error    <= 1'b0;
         i2c_data_rd      <= '0;
      end else if (!m_busy) begin
         if (i2c_ena) begin
            sb_txn();
            m_busy        <= 1'b1;
            i2c_busy      <= 1'b1;
            m_step        <= 0;
            i2c_ack_error <= 1'b0;
            m_ch          <= 2'(i2c_addr - 7'h10);
            m_hung        <= m_hang[2'(i2c_addr - 7'h10)];
            m_ptr         <= i2c_data_wr[31:24];
         end
      end else if (m_hung) begin
         if (!i2c_ena) begin
            m_busy   <= 1'b0;
            m_hung   <= 1'b0;
            i2c_busy <= 1'b0;
         end
      end else begin
         m_step <= m_step + 1;
         if (m_step == 1 || m_step == 3 || m_step == 5)
            i2c_byte_counter <= i2c_byte_counter + 8'd1;
         if (m_step == 8) begin
            m_busy           <= 1'b0;
            i2c_busy         <= 1'b0;
            i2c_byte_counter <= '0;
            i2c_ack_error    <= m_nack[m_ch];
            i2c_data_rd      <= {(m_ptr == 8'h20) ? m_aresp : m_sresp, 16'hBEEF};
         end
      end
   end

   always @(posedge clock) begin
      if (i2c_ena) ena_cycles++;
      if (sweep_done) done_cnt++;
   end

   logic [N-1:0][11:0] e_ang;
   logic [N-1:0][15:0] e_st;
   logic [N-1:0][7:0]  e_cnt;
   logic [N-1:0]       e_valid, e_err;

   task automatic model_reset();
      for (int k = 0; k < N; k++) e_ang[k] = 12'd7;
      e_st    = '0;
      e_cnt   = '0;
      e_valid = '0;
      e_err   = '0;
      exp_q.delete();
   endtask

   task automatic run_sweep(input logic [N-1:0] mask, input logic rs,
                            input logic [15:0] ar, input logic [15:0] sr,
                            input logic [N-1:0] nk, input logic [N-1:0] hg);
      int n;
      int d0;
      txn_t t;
      m_aresp = ar;
      m_sresp = sr;
      m_nack  = nk;
      m_hang  = hg;
      channel_mask = mask;
      read_status  = rs;
      for (int k = 0; k < N; k++) begin
         if (mask[k]) begin
            t.addr = 7'(7'h10 + k);
            t.ptr  = 8'h20;
            exp_q.push_back(t);
            if (nk[k] || hg[k]) begin
               e_err[k]   = 1'b1;
               e_valid[k] = 1'b0;
               if (e_cnt[k] != 8'hFF) e_cnt[k] = e_cnt[k] + 8'd1;
            end else begin
               e_ang[k]   = ar[11:0];
               e_valid[k] = 1'b1;
               e_err[k]   = 1'b0;
               if (rs) begin
                  t.ptr = 8'h22;
                  exp_q.push_back(t);
                  e_st[k] = sr;
               end
            end
         end
      end
      d0 = done_cnt;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("FAIL sweep_timeout: got busy after %0d cycles expected idle", n);
      end
      chk("sweep_done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_angles"}, 64'(angles), 64'(e_ang));
      chk({tag, "_statuses"}, 64'(statuses), 64'(e_st));
      chk({tag, "_err_count"}, 64'(err_count), 64'(e_cnt));
      chk({tag, "_valid_model"}, 64'(valid), 64'(e_valid));
   endtask

   task automatic zero_sweep(input string tag);
      int n;
      int e0;
      logic found;
      channel_mask = '0;
      read_status  = 1'b0;
      e0 = ena_cycles;
      @(negedge clock);
      start = 1'b1;
      n = 0;
      found = 1'b0;
      while (n < 50 && !found) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         n++;
         found = sweep_done;
      end
      chk({tag, "_latency"}, 64'(n), 64'd6);
      chk({tag, "_no_ena"}, 64'(ena_cycles - e0), 64'd0);
      repeat (2) @(negedge clock);
   endtask

   typedef struct {
      logic [N-1:0] mask;
      logic         rs;
      logic [15:0]  aresp;
      logic [15:0]  sresp;
      logic [N-1:0] nack;
      logic [N-1:0] hang;
      logic [N-1:0] exp_valid;
      logic [N-1:0] exp_err;
      int           exp_txns;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n;
      int t0;
      logic found;
      vecs[0] = '{4'hF, 1'b0, 16'h0ABC, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 4};
      vecs[1] = '{4'hF, 1'b0, 16'h0DEF, 16'h0000, 4'h4, 4'h0, 4'hB, 4'h4, 4};
      vecs[2] = '{4'hF, 1'b0, 16'h0555, 16'h0000, 4'h0, 4'h0, 4'hF, 4'h0, 4};
      vecs[3] = '{4'hF, 1'b1, 16'h1123, 16'h5A5A, 4'h0, 4'h0, 4'hF, 4'h0, 8};
      vecs[4] = '{4'hF, 1'b0, 16'h0777, 16'h0000, 4'h0, 4'h2, 4'hD, 4'h2, 4};
      vecs[5] = '{4'h9, 1'b0, 16'h0999, 16'h0000, 4'h8, 4'h0, 4'h5, 4'hA, 2};
      vecs[6] = '{4'hF, 1'b1, 16'h0321, 16'h1234, 4'h1, 4'h0, 4'hE, 4'h1, 7};

      reset        = 1'b1;
      start        = 1'b0;
      continuous   = 1'b0;
      read_status  = 1'b0;
      interval     = '0;
      device_ids   = {7'h13, 7'h12, 7'h11, 7'h10};
      channel_mask = '0;
      m_aresp = '0;
      m_sresp = '0;
      m_nack  = '0;
      m_hang  = '0;
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      chk("rst_angles", 64'(angles), 64'h007007007007);
      chk("rst_flags", {valid, err, err_count, busy, sweep_done, i2c_ena},
          '0);

      for (int i = 0; i < 7; i++) begin
         t0 = txn_cnt;
         run_sweep(vecs[i].mask, vecs[i].rs, vecs[i].aresp, vecs[i].sresp,
                   vecs[i].nack, vecs[i].hang);
         chk($sformatf("v%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
         chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d_txns", i), 64'(txn_cnt - t0), 64'(vecs[i].exp_txns));
         check_outputs($sformatf("v%0d", i));
      end

      zero_sweep("zero_mask");

      // continuous mode with an empty mask: six-cycle sweeps
      continuous = 1'b1;
      interval   = 32'd100;
      @(negedge clock);
      start = 1'b1;
      n = 0;
      found = 1'b0;
      while (n < 50 && !found) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         n++;
         found = sweep_done;
      end
      chk("cont_first_done", 64'(found), 64'd1);
      n = 0;
      found = 1'b0;
      while (n < 500 && !found) begin
         @(posedge clock);
         #1;
         n++;
         found = sweep_done;
      end
      chk("cont_spacing", 64'(n), 64'd107);
      repeat (20) @(negedge clock);
      chk("cont_busy_in_wait", 64'(busy), 64'd1);
      continuous = 1'b0;
      repeat (2) @(negedge clock);
      chk("cont_drop_idle", 64'(busy), 64'd0);

      // saturate channel 0's failure counter
      for (int i = 0; i < 258; i++)
         run_sweep(4'h1, 1'b0, 16'h0000, 16'h0000, 4'h1, 4'h0);
      check_outputs("sat");
      chk("sat_count0", 64'(err_count[7:0]), 64'hFF);

      // async reset while the enable is high
      channel_mask = 4'hF;
      m_nack = '0;
      m_hang = '0;
      @(negedge clock);
      start = 1'b1;
      n = 0;
      found = 1'b0;
      while (n < 20 && !found) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         n++;
         found = i2c_ena;
      end
      chk("ena_before_reset", 64'(i2c_ena), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("reset_ena_now", 64'(i2c_ena), 64'd0);
      chk("reset_angles", 64'(angles), 64'h007007007007);
      chk("reset_state", {valid, err_count, busy}, '0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      zero_sweep("post_reset");
      check_outputs("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
